// File: rtl/pll_reconf_pkg.sv
// pll_reconf_pkg: state encoding and default constants
// shared by the PLL reconfiguration sequencer files.
package pll_reconf_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ROM_RD    = 3'd1,
    S_WR        = 3'd2,
    S_TRIG      = 3'd3,
    S_BUSY_WAIT = 3'd4,
    S_LOCK_WAIT = 3'd5,
    S_ERR       = 3'd6
  } seq_state_t;

  localparam int DEF_LOCK_STB = 1024;
  localparam int DEF_LOCK_TO  = 1048575;
  localparam int DEF_BUSY_TO  = 65535;

  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/pll_lock_mon.sv
// pll_lock_mon: lock synchroniser, stable-lock counter,
// lock-wait timeout counter and lock-loss edge detect.
module pll_lock_mon
  import pll_reconf_pkg::*;
#(
  parameter int LOCK_STB = DEF_LOCK_STB,
  parameter int LOCK_TO  = DEF_LOCK_TO
) (
  input  logic CLK,
  input  logic RSTX,
  input  logic PLL_LOCKED,
  input  logic EN,
  output logic LOCK_OK,
  output logic LOCK_TMO,
  output logic LOST
);

  localparam int SW = cnt_w(LOCK_STB);
  localparam int TW = cnt_w(LOCK_TO);
  localparam logic [SW-1:0] STB_MAX = SW'(LOCK_STB);
  localparam logic [TW-1:0] TO_MAX = TW'(LOCK_TO);

  logic          lk_s1, lk_s2, lk_d;
  logic [SW-1:0] stb_cnt;
  logic [TW-1:0] tmo_cnt;

  // two-flop sync of the async lock plus a delayed copy for edge detect
  always_ff @(posedge CLK or negedge RSTX) begin
    if (!RSTX) begin
      lk_s1 <= 1'b0;
      lk_s2 <= 1'b0;
      lk_d  <= 1'b0;
    end else begin
      lk_s1 <= PLL_LOCKED;
      lk_s2 <= lk_s1;
      lk_d  <= lk_s2;
    end
  end

  // counters run only while enabled; stable count restarts on any lock drop
  always_ff @(posedge CLK or negedge RSTX) begin
    if (!RSTX) begin
      stb_cnt <= '0;
      tmo_cnt <= '0;
    end else begin
      if (!EN || !lk_s2)
        stb_cnt <= '0;
      else if (stb_cnt != STB_MAX)
        stb_cnt <= stb_cnt + 1'b1;
      if (!EN)
        tmo_cnt <= '0;
      else if (tmo_cnt != TO_MAX)
        tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

  assign LOCK_OK  = (stb_cnt == STB_MAX);
  assign LOCK_TMO = (tmo_cnt == TO_MAX);
  assign LOST     = lk_d & ~lk_s2;

endmodule

// File: rtl/pll_reconf_seq.sv
// pll_reconf_seq: loads a ROM profile into the PLL reconfig block,
// triggers it and waits for stable lock. Macro: PLL_RECONF_RETRY_EN.
module pll_reconf_seq
  import pll_reconf_pkg::*;
#(
  parameter int WIDX_W   = 4,
  parameter int DW       = 9,
  parameter int ROM_LAT  = 2,
  parameter int LOCK_STB = DEF_LOCK_STB,
  parameter int LOCK_TO  = DEF_LOCK_TO,
  parameter int BUSY_TO  = DEF_BUSY_TO
) (
  input  logic              CLK,
  input  logic              RSTX,
  input  logic              PLL_CHG,
  input  logic [7:0]        PLL_ADDR,
  output logic [8+WIDX_W-1:0] ROM_ADDR,
  input  logic [DW-1:0]     ROM_Q,
  output logic              RC_WE,
  output logic [WIDX_W-1:0] RC_WIDX,
  output logic [DW-1:0]     RC_WDATA,
  output logic              RC_RECONFIG,
  input  logic              RC_BUSY,
  input  logic              PLL_LOCKED,
  output logic              PLL_RSTX,
  output logic              BUSY,
  output logic              ERR,
  output logic [7:0]        CUR_PROF
);

  localparam int LW = cnt_w(ROM_LAT);
  localparam int BW = cnt_w(BUSY_TO);
  localparam logic [LW-1:0] LLAST = LW'(ROM_LAT - 1);
  localparam logic [BW-1:0] BMAX = BW'(BUSY_TO);

  seq_state_t        state_q, state_d;
  logic [WIDX_W-1:0] widx_q, widx_d;
  logic [LW-1:0]     lat_q, lat_d;
  logic [BW-1:0]     bcnt_q, bcnt_d;
  logic [7:0]        prof_q, prof_d;
  logic [7:0]        paddr_q, paddr_d;
  logic              pend_q, pend_d;
  logic              rstx_q, rstx_d;
  logic              err_q, err_d;
`ifdef PLL_RECONF_RETRY_EN
  logic [1:0]        retry_q, retry_d;
`endif
  logic              idle_like, start, tmo;
  logic [7:0]        start_addr;
  logic              lock_en, lock_ok, lock_tmo, lost;

  assign lock_en = (state_q == S_LOCK_WAIT);

  pll_lock_mon #(
    .LOCK_STB(LOCK_STB),
    .LOCK_TO (LOCK_TO)
  ) u_lock (
    .CLK       (CLK),
    .RSTX      (RSTX),
    .PLL_LOCKED(PLL_LOCKED),
    .EN        (lock_en),
    .LOCK_OK   (lock_ok),
    .LOCK_TMO  (lock_tmo),
    .LOST      (lost)
  );

  // next-state: sequence steps, request capture, start and timeout handling
  always_comb begin
    state_d = state_q;
    widx_d  = widx_q;
    lat_d   = lat_q;
    bcnt_d  = bcnt_q;
    prof_d  = prof_q;
    paddr_d = paddr_q;
    pend_d  = pend_q;
    rstx_d  = rstx_q;
    err_d   = err_q;
`ifdef PLL_RECONF_RETRY_EN
    retry_d = retry_q;
`endif
    idle_like  = (state_q == S_IDLE) || (state_q == S_ERR);
    start      = idle_like && (PLL_CHG || pend_q);
    start_addr = PLL_CHG ? PLL_ADDR : paddr_q;
    tmo        = 1'b0;
    if (PLL_CHG && !idle_like) begin
      pend_d  = 1'b1;
      paddr_d = PLL_ADDR;
    end
    unique case (state_q)
      S_IDLE: begin
        if (lost) begin
          rstx_d  = 1'b0;
          state_d = S_LOCK_WAIT;
        end
      end
      S_ROM_RD: begin
        if (lat_q == LLAST)
          state_d = S_WR;
        else
          lat_d = lat_q + 1'b1;
      end
      S_WR: begin
        if (widx_q == '1) begin
          rstx_d  = 1'b0;
          bcnt_d  = '0;
          state_d = S_TRIG;
        end else begin
          widx_d  = widx_q + 1'b1;
          lat_d   = '0;
          state_d = S_ROM_RD;
        end
      end
      S_TRIG: begin
        bcnt_d  = bcnt_q + 1'b1;
        state_d = S_BUSY_WAIT;
      end
      S_BUSY_WAIT: begin
        bcnt_d = bcnt_q + 1'b1;
        if (!RC_BUSY && bcnt_q > BW'(1))
          state_d = S_LOCK_WAIT;
        else if (bcnt_q == BMAX)
          tmo = 1'b1;
      end
      S_LOCK_WAIT: begin
        if (lock_ok) begin
          rstx_d  = 1'b1;
          err_d   = 1'b0;
          state_d = S_IDLE;
        end else if (lock_tmo) begin
          tmo = 1'b1;
        end
      end
      S_ERR: begin
        state_d = S_ERR;
      end
      default: state_d = S_IDLE;
    endcase
    if (start) begin
      state_d = S_ROM_RD;
      widx_d  = '0;
      lat_d   = '0;
      prof_d  = start_addr;
      pend_d  = 1'b0;
`ifdef PLL_RECONF_RETRY_EN
      retry_d = '0;
`endif
    end
    if (tmo) begin
`ifdef PLL_RECONF_RETRY_EN
      if (retry_q < 2'd2) begin
        retry_d = retry_q + 1'b1;
        widx_d  = '0;
        lat_d   = '0;
        state_d = S_ROM_RD;
      end else begin
        err_d   = 1'b1;
        state_d = S_ERR;
      end
`else
      err_d   = 1'b1;
      state_d = S_ERR;
`endif
    end
  end

  // sequencer registers; reset starts with the initial lock wait
  always_ff @(posedge CLK or negedge RSTX) begin
    if (!RSTX) begin
      state_q <= S_LOCK_WAIT;
      widx_q  <= '0;
      lat_q   <= '0;
      bcnt_q  <= '0;
      prof_q  <= '0;
      paddr_q <= '0;
      pend_q  <= 1'b0;
      rstx_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef PLL_RECONF_RETRY_EN
      retry_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      widx_q  <= widx_d;
      lat_q   <= lat_d;
      bcnt_q  <= bcnt_d;
      prof_q  <= prof_d;
      paddr_q <= paddr_d;
      pend_q  <= pend_d;
      rstx_q  <= rstx_d;
      err_q   <= err_d;
`ifdef PLL_RECONF_RETRY_EN
      retry_q <= retry_d;
`endif
    end
  end

  assign ROM_ADDR    = {prof_q, widx_q};
  assign RC_WE       = (state_q == S_WR);
  assign RC_WIDX     = widx_q;
  assign RC_WDATA    = RC_WE ? ROM_Q : '0;
  assign RC_RECONFIG = (state_q == S_TRIG);
  assign PLL_RSTX    = rstx_q;
  assign BUSY        = (state_q != S_IDLE);
  assign ERR         = err_q;
  assign CUR_PROF    = prof_q;

endmodule

// File: tb/tb_pll_reconf_seq.sv
// tb_pll_reconf_seq: directed/random bench with ROM, reconfig-block
// and PLL behavioural models for pll_reconf_seq.
module tb_pll_reconf_seq;

  localparam int STB = 100;
  localparam int LTO = 3000;
  localparam int BTO = 200;
  localparam int RL  = 2;
`ifdef PLL_RECONF_RETRY_EN
  localparam int EXP_RC = 3;
`else
  localparam int EXP_RC = 1;
`endif

  logic        CLK = 1'b0;
  logic        RSTX = 1'b0;
  logic        PLL_CHG = 1'b0;
  logic [7:0]  PLL_ADDR = 8'd0;
  logic [11:0] ROM_ADDR;
  logic [8:0]  ROM_Q;
  logic        RC_WE;
  logic [3:0]  RC_WIDX;
  logic [8:0]  RC_WDATA;
  logic        RC_RECONFIG;
  logic        RC_BUSY = 1'b0;
  logic        PLL_LOCKED = 1'b1;
  logic        PLL_RSTX;
  logic        BUSY;
  logic        ERR;
  logic [7:0]  CUR_PROF;

  logic        busy_stuck = 1'b0;
  logic        lock_kill = 1'b0;
  int          busy_left = 0;
  int          lock_gap = 0;
  int          cyc = 0;
  int          rc_cnt = 0;
  int          rc_cyc = 0;
  int          total = 0;
  int          bad = 0;

  logic [8:0]  rom_tab [4096];
  logic [11:0] rp0, rp1;

  typedef struct packed {
    logic [11:0] a;
    logic [3:0]  w;
    logic [8:0]  d;
  } wr_t;
  wr_t wq[$];
  int  wcyc[$];

  pll_reconf_seq #(
    .WIDX_W(4), .DW(9), .ROM_LAT(RL),
    .LOCK_STB(STB), .LOCK_TO(LTO), .BUSY_TO(BTO)
  ) dut (
    .CLK(CLK), .RSTX(RSTX),
    .PLL_CHG(PLL_CHG), .PLL_ADDR(PLL_ADDR),
    .ROM_ADDR(ROM_ADDR), .ROM_Q(ROM_Q),
    .RC_WE(RC_WE), .RC_WIDX(RC_WIDX),
    .RC_WDATA(RC_WDATA), .RC_RECONFIG(RC_RECONFIG),
    .RC_BUSY(RC_BUSY), .PLL_LOCKED(PLL_LOCKED),
    .PLL_RSTX(PLL_RSTX), .BUSY(BUSY),
    .ERR(ERR), .CUR_PROF(CUR_PROF)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc++;

  // synchronous ROM with RL cycles of latency
  always @(posedge CLK) begin
    rp0 <= ROM_ADDR;
    rp1 <= rp0;
  end
  assign ROM_Q = rom_tab[rp1];

  // record every write strobe and reconfig trigger
  always @(negedge CLK) begin
    if (RC_WE) begin
      wq.push_back(wr_t'({ROM_ADDR, RC_WIDX, RC_WDATA}));
      wcyc.push_back(cyc);
    end
    if (RC_RECONFIG) begin
      rc_cnt++;
      rc_cyc = cyc;
    end
  end

  // reconfig block goes busy and PLL loses lock for a while after each trigger
  initial begin
    forever begin
      @(negedge CLK);
      if (busy_left > 0) busy_left--;
      if (lock_gap > 0) lock_gap--;
      if (RC_RECONFIG) begin
        busy_left = $urandom_range(1, 8);
        lock_gap  = $urandom_range(2, 20);
      end
      RC_BUSY    = busy_stuck || (busy_left > 0);
      PLL_LOCKED = !lock_kill && (lock_gap == 0);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_rng(input string tag, input int obs,
                         input int lo, input int hi);
    total++;
    assert (obs >= lo && obs <= hi) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
    end
  endtask

  task automatic step();
    @(negedge CLK);
    #1;
  endtask

  task automatic req(input logic [7:0] a);
    PLL_ADDR = a;
    PLL_CHG  = 1'b1;
    step();
    PLL_CHG  = 1'b0;
    PLL_ADDR = 8'($urandom);
  endtask

  task automatic wait_done(input int exp_rc, input int lim);
    int n = 0;
    while (!(!BUSY && rc_cnt == exp_rc) && n < lim) begin
      step();
      n++;
    end
    chk_rng("done_wait", n, 0, lim - 1);
  endtask

  task automatic check_prof(input int base, input logic [7:0] p);
    logic [11:0] a;
    chk("wr_avail", 32'(wq.size() >= base + 16), 32'd1);
    if (wq.size() >= base + 16) begin
      for (int i = 0; i < 16; i++) begin
        a = {p, 4'(i)};
        chk("wr_addr", 32'(wq[base+i].a), 32'(a));
        chk("wr_widx", 32'(wq[base+i].w), 32'(i));
        chk("wr_data", 32'(wq[base+i].d), 32'(rom_tab[a]));
        if (i > 0)
          chk("wr_gap", 32'(wcyc[base+i] - wcyc[base+i-1]), 32'(RL + 1));
      end
    end
  endtask

  initial begin
    int n, base, rc0;
    logic [7:0] p;
    for (int i = 0; i < 4096; i++) rom_tab[i] = 9'($urandom);
    repeat (3) step();

    chk("rst_busy", BUSY, 1);
    chk("rst_rstx", PLL_RSTX, 0);
    chk("rst_err", ERR, 0);
    chk("rst_prof", CUR_PROF, 0);
    chk("rst_we", RC_WE, 0);
    chk("rst_rc", RC_RECONFIG, 0);
    chk("rst_addr", ROM_ADDR, 0);
    chk("rst_wdata", RC_WDATA, 0);

    RSTX = 1'b1;
    n = 0;
    while (!PLL_RSTX && n < 4 * STB) begin
      step();
      n++;
    end
    chk_rng("init_lock_cyc", n, STB + 2, STB + 4);
    chk("init_busy", BUSY, 0);
    chk("init_err", ERR, 0);

    for (int k = 0; k < 3; k++) begin
      p = (k == 0) ? 8'd12 : 8'($urandom);
      base = wq.size();
      rc0 = rc_cnt;
      req(p);
      wait_done(rc0 + 1, 1000);
      chk("prof_wrs", 32'(wq.size() - base), 16);
      chk("prof_rc", 32'(rc_cnt - rc0), 1);
      check_prof(base, p);
      chk("prof_cur", CUR_PROF, p);
      chk("prof_err", ERR, 0);
      chk("prof_rstx", PLL_RSTX, 1);
    end

    p = 8'($urandom_range(16, 255));
    base = wq.size();
    rc0 = rc_cnt;
    req(p);
    repeat (4) step();
    req(8'd3);
    repeat (10) step();
    req(8'd5);
    wait_done(rc0 + 2, 2000);
    chk("pend_wrs", 32'(wq.size() - base), 32);
    check_prof(base, p);
    check_prof(base + 16, 8'd5);
    chk("pend_cur", CUR_PROF, 5);
    repeat (30) step();
    chk("pend_once", 32'(rc_cnt - rc0), 2);
    chk("pend_idle", BUSY, 0);

    base = wq.size();
    rc0 = rc_cnt;
    lock_kill = 1'b1;
    step();
    n = 0;
    while (PLL_RSTX && n < 10) begin
      step();
      n++;
    end
    chk_rng("lost_fall_cyc", n, 1, 3);
    chk("lost_busy", BUSY, 1);
    lock_kill = 1'b0;
    step();
    n = 0;
    while (!PLL_RSTX && n < 4 * STB) begin
      step();
      n++;
    end
    chk_rng("lost_rise_cyc", n, STB + 2, STB + 4);
    chk("lost_idle", BUSY, 0);
    chk("lost_nowr", 32'(wq.size() - base), 0);
    chk("lost_norc", 32'(rc_cnt - rc0), 0);

    base = wq.size();
    rc0 = rc_cnt;
    req(8'($urandom_range(1, 255)));
    n = 0;
    while (!RC_WE && n < 50) begin
      step();
      n++;
    end
    chk("rstm_in_wr", RC_WE, 1);
    RSTX = 1'b0;
    #1;
    chk("rstm_busy", BUSY, 1);
    chk("rstm_rstx", PLL_RSTX, 0);
    chk("rstm_err", ERR, 0);
    chk("rstm_prof", CUR_PROF, 0);
    chk("rstm_we", RC_WE, 0);
    chk("rstm_rc", RC_RECONFIG, 0);
    chk("rstm_addr", ROM_ADDR, 0);
    chk("rstm_widx", RC_WIDX, 0);
    repeat (2) step();
    RSTX = 1'b1;
    wait_done(rc0, 4 * STB);
    chk("rstm_wrs", 32'(wq.size() - base), 1);
    chk("rstm_prof_after", CUR_PROF, 0);
    chk("rstm_rstx_after", PLL_RSTX, 1);

    busy_stuck = 1'b1;
    p = 8'($urandom);
    base = wq.size();
    rc0 = rc_cnt;
    req(p);
    n = 0;
    while (!ERR && n < 4 * (BTO + 200)) begin
      step();
      n++;
    end
    chk("tmo_err", ERR, 1);
    chk("tmo_busy", BUSY, 1);
    chk("tmo_rstx", PLL_RSTX, 0);
    chk("tmo_rc", 32'(rc_cnt - rc0), 32'(EXP_RC));
    chk("tmo_wrs", 32'(wq.size() - base), 32'(16 * EXP_RC));
    chk_rng("tmo_lat", cyc - rc_cyc, BTO, BTO + 2);
    repeat (20) step();
    chk("tmo_sticky", ERR, 1);
    chk("tmo_hold", BUSY, 1);
    chk("tmo_norc", 32'(rc_cnt - rc0), 32'(EXP_RC));

    busy_stuck = 1'b0;
    p = 8'($urandom);
    base = wq.size();
    rc0 = rc_cnt;
    req(p);
    wait_done(rc0 + 1, 1000);
    check_prof(base, p);
    chk("rec_cur", CUR_PROF, p);
    chk("rec_err", ERR, 0);
    chk("rec_rstx", PLL_RSTX, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
